// File: rtl/frame_buf_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buf_ctrl
//
// Sequences a single-frame pixel store between an incoming and an outgoing
// pixel stream. The controller owns all store addressing: it fills the store
// with exactly one frame (FILL), then drains it in address order through a
// 2-entry output FIFO with full downstream backpressure (DRAIN), then re-arms.
// The store itself is external: one write port, one registered read port with
// 1-cycle read latency.
//
// Optional feature (macro FBC_FRAME_CNT_EN):
//   defined   -> adds output frame_count[15:0], +1 per frame_done, wraps.
//   undefined -> port and counter absent; all other behaviour identical.
//
// Ports:
//   clk, aresetn          clock; synchronous active-low reset
//   s_tdata/valid/last    input stream (s_tlast is checked, never used to count)
//   s_tready              input accept, high in FILL only
//   m_tdata/valid/last    output stream, m_tlast on the beat from the last address
//   m_tready              downstream accept
//   mem_wr_en/addr/data   store write port (combinational from the s handshake)
//   mem_rd_en/addr        store read request
//   mem_rd_data           store read data, valid 1 cycle after mem_rd_en
//   frame_done            1-cycle pulse after the final output beat is accepted
//   tlast_err             1-cycle pulse after a beat whose s_tlast is misplaced
// -----------------------------------------------------------------------------
module frame_buf_ctrl #(
  parameter  int PIXELS_PER_BEAT = 16,
  parameter  int IMAGE_DIM       = 512,
  parameter  int DATA_WIDTH      = PIXELS_PER_BEAT * 8,
  localparam int MEM_DEPTH       = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int ADDR_WIDTH      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  frame_done,
  output logic                  tlast_err
`ifdef FBC_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  rd_all;        // every address of this frame has been read
  logic                  inflight;      // a read was issued last cycle
  logic                  inflight_last; // ...and it was the final address

  // Output FIFO, entry 0 is the head; pops shift entry 1 down.
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];

  logic                  s_fire;
  logic                  m_fire;
  logic                  wr_last;
  logic [2:0]            occ;

  assign s_fire  = s_tvalid & s_tready;
  assign m_fire  = m_tvalid & m_tready;
  assign wr_last = (wr_cnt == LAST_ADDR);

  // Write path: zero latency, the store captures on the handshake edge.
  assign mem_wr_en   = s_fire;
  assign mem_wr_addr = wr_cnt;
  assign mem_wr_data = s_fire ? s_tdata : '0;

  assign m_tvalid = (fifo_count != 2'd0);
  assign m_tdata  = fifo_data[0];
  assign m_tlast  = m_tvalid & fifo_last[0];

  // Occupancy counts a pop happening this cycle as already free, so a read can
  // be issued into the slot being vacated; this is what sustains 1 beat/cycle
  // while still never holding more than 2 words buffered plus in flight.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, m_fire};

  assign mem_rd_en   = (state == ST_DRAIN) && !rd_all && (occ < 3'd2);
  assign mem_rd_addr = rd_cnt;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= ST_FILL;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      rd_all        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_count    <= 2'd0;
      // NOTE: FIFO storage is reset too, because its head drives m_tdata
      // directly and that output must read 0 out of reset.
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
      s_tready      <= 1'b0;
      frame_done    <= 1'b0;
      tlast_err     <= 1'b0;
`ifdef FBC_FRAME_CNT_EN
      frame_count   <= '0;
`endif
    end else begin
      frame_done    <= 1'b0;
      tlast_err     <= 1'b0;
      inflight      <= mem_rd_en;
      inflight_last <= mem_rd_en && (rd_cnt == LAST_ADDR);

      // FIFO: push is the word returned for last cycle's read.
      if (inflight && !m_fire) begin
        fifo_data[fifo_count[0]] <= mem_rd_data;
        fifo_last[fifo_count[0]] <= inflight_last;
        fifo_count               <= fifo_count + 2'd1;
      end else if (!inflight && m_fire) begin
        fifo_data[0] <= fifo_data[1];
        fifo_last[0] <= fifo_last[1];
        fifo_count   <= fifo_count - 2'd1;
      end else if (inflight && m_fire) begin
        if (fifo_count == 2'd2) begin
          fifo_data[0] <= fifo_data[1];
          fifo_last[0] <= fifo_last[1];
          fifo_data[1] <= mem_rd_data;
          fifo_last[1] <= inflight_last;
        end else begin
          fifo_data[0] <= mem_rd_data;
          fifo_last[0] <= inflight_last;
        end
      end

      unique case (state)
        ST_FILL: begin
          s_tready <= 1'b1;
          if (s_fire) begin
            tlast_err <= (s_tlast != wr_last);
            if (wr_last) begin
              wr_cnt   <= '0;
              state    <= ST_DRAIN;
              s_tready <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          s_tready <= 1'b0;
          if (mem_rd_en) begin
            if (rd_cnt == LAST_ADDR) rd_all <= 1'b1;
            else                     rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
          end
          if (m_fire && fifo_last[0]) begin
            frame_done <= 1'b1;
            rd_cnt     <= '0;
            rd_all     <= 1'b0;
            state      <= ST_FILL;
            s_tready   <= 1'b1;
`ifdef FBC_FRAME_CNT_EN
            frame_count <= frame_count + 16'd1;
`endif
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_buf_ctrl
//
// Directed bench for frame_buf_ctrl with IMAGE_DIM=8, PIXELS_PER_BEAT=16
// (MEM_DEPTH=4). A behavioural store with a registered read port sits on the
// mem_* interface. A negedge monitor records output beats, pulses, stalls and
// the reads-outstanding level; each test task compares against hand-computed
// values. Build with +define+FBC_FRAME_CNT_EN to also check frame_count.
// -----------------------------------------------------------------------------
module tb_frame_buf_ctrl;

  localparam int PPB   = 16;
  localparam int DIM   = 8;
  localparam int DW    = PPB * 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam logic [DW-1:0] BASE_A = 'hA0;
  localparam logic [DW-1:0] BASE_B = 'hB0;
  localparam logic [DW-1:0] BASE_C = 'hC0;
  localparam logic [DW-1:0] BASE_D = 'hD0;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          frame_done;
  logic          tlast_err;
`ifdef FBC_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  always #5 clk = ~clk;

  frame_buf_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .frame_done(frame_done), .tlast_err(tlast_err)
`ifdef FBC_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  // Behavioural single-frame store, 1-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  int total = 0;
  int bad   = 0;

  // Monitor, sampled mid-cycle.
  logic [DW-1:0] got_q [$];
  logic          got_last_q [$];
  logic [15:0]   fc_q [$];
  int            done_cnt, err_cnt, stab_err, stall_cnt, issued, accepted, max_out;
  logic          held = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  always @(negedge clk) begin
    if (held && (!m_tvalid || m_tdata !== held_data || m_tlast !== held_last))
      stab_err++;
    held = m_tvalid && !m_tready;
    if (held) begin
      held_data = m_tdata;
      held_last = m_tlast;
      stall_cnt++;
    end
    if (mem_rd_en) issued++;
    if (m_tvalid && m_tready) begin
      got_q.push_back(m_tdata);
      got_last_q.push_back(m_tlast);
      accepted++;
    end
    if (issued - accepted > max_out) max_out = issued - accepted;
    if (frame_done) begin
      done_cnt++;
`ifdef FBC_FRAME_CNT_EN
      fc_q.push_back(frame_count);
`else
      fc_q.push_back(16'd0);
`endif
    end
    if (tlast_err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_last_q.delete();
    fc_q.delete();
    done_cnt = 0; err_cnt = 0; stab_err = 0; stall_cnt = 0;
    issued = 0; accepted = 0; max_out = 0;
    held = 1'b0;
  endtask

  task automatic reset_dut();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    clear_mon();
  endtask

  // Sends one frame of DEPTH beats (base+i), s_tlast per last_mask bit.
  // Returns how many cycles the first beat waited for s_tready.
  task automatic send_frame(input logic [DW-1:0] base, input logic [DEPTH-1:0] last_mask,
                            output int wait0);
    int w;
    wait0 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = 0;
      s_tdata  = base + DW'(i);
      s_tlast  = last_mask[i];
      s_tvalid = 1'b1;
      #1;
      while (!s_tready && w < 50) begin
        tick();
        #1;
        w++;
      end
      if (i == 0) wait0 = w;
      total++;
      if (!(s_tready === 1'b1 && mem_wr_en === 1'b1 && mem_wr_addr === AW'(i))) begin
        bad++;
        $display("FAIL write beat %0d: ready=%b wr_en=%b addr=%0d, want ready=1 wr_en=1 addr=%0d",
                 i, s_tready, mem_wr_en, mem_wr_addr, i);
      end
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = BASE_A;
    m_tready = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if ({s_tready, m_tvalid, m_tlast, mem_rd_en, mem_wr_en, frame_done, tlast_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset ctrl: rdy=%b mv=%b ml=%b rd=%b wr=%b done=%b err=%b, want all 0",
               s_tready, m_tvalid, m_tlast, mem_rd_en, mem_wr_en, frame_done, tlast_err);
    end
    total++;
    if (mem_wr_addr !== '0 || mem_rd_addr !== '0 || m_tdata !== '0 || mem_wr_data !== '0) begin
      bad++;
      $display("FAIL reset data: wa=%0d ra=%0d md=%0h wd=%0h, want all 0",
               mem_wr_addr, mem_rd_addr, m_tdata, mem_wr_data);
    end
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    tick();
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL ready after release: got %b want 1", s_tready);
    end
    clear_mon();
  endtask

  task automatic test_basic();
    int w;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    reset_dut();
    m_tready = 1'b1;
    send_frame(BASE_A, 4'b1000, w);
    // Now one cycle into DRAIN; beats expected in cycles 2..5, done in 6.
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_valid = (c >= 2 && c <= 5);
      exp_data  = BASE_A + DW'(c - 2);
      total++;
      if (m_tvalid !== exp_valid || frame_done !== (c == 6)) begin
        bad++;
        $display("FAIL basic cycle %0d: valid=%b done=%b, want valid=%b done=%b",
                 c, m_tvalid, frame_done, exp_valid, (c == 6));
      end
      if (exp_valid) begin
        total++;
        if (m_tdata !== exp_data || m_tlast !== (c == 5)) begin
          bad++;
          $display("FAIL basic beat %0d: data=%0h last=%b, want data=%0h last=%b",
                   c - 2, m_tdata, m_tlast, exp_data, (c == 5));
        end
      end
      if (c == 6) begin
        total++;
        if (s_tready !== 1'b1) begin
          bad++;
          $display("FAIL basic rearm: s_tready=%b want 1", s_tready);
        end
      end
      tick();
    end
    total++;
    if (err_cnt != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL basic pulses: tlast_err=%0d frame_done=%0d, want 0 and 1", err_cnt, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int w;
    reset_dut();
    m_tready = 1'b1;
    send_frame(BASE_A, 4'b1000, w);
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      m_tready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    m_tready = 1'b1;
    total++;
    if (done_cnt != 1 || got_q.size() != DEPTH) begin
      bad++;
      $display("FAIL bp count: done=%0d beats=%0d, want 1 and %0d", done_cnt, got_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (got_q[i] !== BASE_A + DW'(i) || got_last_q[i] !== (i == DEPTH - 1)) begin
          bad++;
          $display("FAIL bp beat %0d: data=%0h last=%b, want data=%0h last=%b",
                   i, got_q[i], got_last_q[i], BASE_A + DW'(i), (i == DEPTH - 1));
        end
      end
    end
    total++;
    if (stab_err != 0 || stall_cnt == 0) begin
      bad++;
      $display("FAIL bp stall: unstable=%0d stalls=%0d, want 0 and >0", stab_err, stall_cnt);
    end
    total++;
    if (max_out > 2) begin
      bad++;
      $display("FAIL bp outstanding: max=%0d want <=2", max_out);
    end
  endtask

  task automatic test_tlast_err();
    int w;
    reset_dut();
    m_tready = 1'b1;
    send_frame(BASE_A, 4'b1010, w);
    for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
    total++;
    if (err_cnt != 1 || got_q.size() != DEPTH || done_cnt != 1) begin
      bad++;
      $display("FAIL tlast early: errs=%0d beats=%0d done=%0d, want 1 %0d 1",
               err_cnt, got_q.size(), done_cnt, DEPTH);
    end
    // Missing s_tlast on the final beat.
    clear_mon();
    send_frame(BASE_B, 4'b0000, w);
    for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
    total++;
    if (err_cnt != 1 || got_q.size() != DEPTH || done_cnt != 1) begin
      bad++;
      $display("FAIL tlast missing: errs=%0d beats=%0d done=%0d, want 1 %0d 1",
               err_cnt, got_q.size(), done_cnt, DEPTH);
    end else begin
      total++;
      if (got_q[DEPTH-1] !== BASE_B + DW'(DEPTH - 1) || got_last_q[DEPTH-1] !== 1'b1) begin
        bad++;
        $display("FAIL tlast missing beat: data=%0h last=%b, want %0h last=1",
                 got_q[DEPTH-1], got_last_q[DEPTH-1], BASE_B + DW'(DEPTH - 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    // Reset during fill.
    reset_dut();
    m_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tdata  = BASE_A + DW'(i);
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    clear_mon();
    send_frame(BASE_B, 4'b1000, w);
    for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
    total++;
    if (got_q.size() != DEPTH || done_cnt != 1) begin
      bad++;
      $display("FAIL reset fill count: beats=%0d done=%0d, want %0d 1", got_q.size(), done_cnt, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (got_q[i] !== BASE_B + DW'(i)) begin
          bad++;
          $display("FAIL reset fill beat %0d: got %0h want %0h", i, got_q[i], BASE_B + DW'(i));
        end
      end
    end
    // Reset during drain with the FIFO full.
    reset_dut();
    send_frame(BASE_A, 4'b1000, w);
    repeat (6) tick();
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== BASE_A) begin
      bad++;
      $display("FAIL stalled head: valid=%b data=%0h, want 1 %0h", m_tvalid, m_tdata, BASE_A);
    end
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    clear_mon();
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL fifo discard: m_tvalid=%b want 0", m_tvalid);
    end
    m_tready = 1'b1;
    send_frame(BASE_C, 4'b1000, w);
    for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
    total++;
    if (got_q.size() != DEPTH) begin
      bad++;
      $display("FAIL reset drain count: beats=%0d want %0d", got_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (got_q[i] !== BASE_C + DW'(i)) begin
          bad++;
          $display("FAIL reset drain beat %0d: got %0h want %0h", i, got_q[i], BASE_C + DW'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    reset_dut();
    m_tready = 1'b1;
    send_frame(BASE_C, 4'b1000, w1);
    send_frame(BASE_D, 4'b1000, w2);
    for (int c = 0; c < 60 && done_cnt < 2; c++) tick();
    // s_tready stays low for the 6 drain cycles before re-arming.
    total++;
    if (w2 != 6) begin
      bad++;
      $display("FAIL b2b ready gap: waited %0d cycles, want 6", w2);
    end
    total++;
    if (got_q.size() != 2 * DEPTH || done_cnt != 2 || err_cnt != 0) begin
      bad++;
      $display("FAIL b2b count: beats=%0d done=%0d errs=%0d, want %0d 2 0",
               got_q.size(), done_cnt, err_cnt, 2 * DEPTH);
    end else begin
      for (int i = 0; i < 2 * DEPTH; i++) begin
        total++;
        if (got_q[i] !== ((i < DEPTH) ? BASE_C + DW'(i) : BASE_D + DW'(i - DEPTH))) begin
          bad++;
          $display("FAIL b2b beat %0d: got %0h", i, got_q[i]);
        end
      end
`ifdef FBC_FRAME_CNT_EN
      total++;
      if (fc_q[0] !== 16'd1 || fc_q[1] !== 16'd2) begin
        bad++;
        $display("FAIL frame_count: got %0d,%0d want 1,2", fc_q[0], fc_q[1]);
      end
`endif
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_tlast_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
